ex_block: RTL and testbench



---
 rtl/ex_pkg.sv | 66 ++++++
 rtl/ex_alu.sv | 55 +++++
 rtl/ex_block.sv | 79 +++++++
 tb/tb_ex_block.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared opcode map, flag indices and opcode classification for the execute stage.
package ex_pkg;

  localparam int DW  = 16;
  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPW-1:0] OP_MOV  = 6'b000010;
  localparam logic [OPW-1:0] OP_AND  = 6'b000100;
  localparam logic [OPW-1:0] OP_OR   = 6'b000101;
  localparam logic [OPW-1:0] OP_XOR  = 6'b000110;
  localparam logic [OPW-1:0] OP_NOT  = 6'b000111;
  localparam logic [OPW-1:0] OP_ADI  = 6'b001000;
  localparam logic [OPW-1:0] OP_SBI  = 6'b001001;
  localparam logic [OPW-1:0] OP_MVI  = 6'b001010;
  localparam logic [OPW-1:0] OP_ANI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI  = 6'b001101;
  localparam logic [OPW-1:0] OP_XORI = 6'b001110;
  localparam logic [OPW-1:0] OP_NTI  = 6'b001111;
  localparam logic [OPW-1:0] OP_RET  = 6'b010000;
  localparam logic [OPW-1:0] OP_HLT  = 6'b010001;
  localparam logic [OPW-1:0] OP_ST   = 6'b010100;
  localparam logic [OPW-1:0] OP_LD   = 6'b010101;
  localparam logic [OPW-1:0] OP_IN   = 6'b010110;
  localparam logic [OPW-1:0] OP_OUT  = 6'b010111;
  localparam logic [OPW-1:0] OP_JMP  = 6'b011000;
  localparam logic [OPW-1:0] OP_LS   = 6'b011001;
  localparam logic [OPW-1:0] OP_RS   = 6'b011010;
  localparam logic [OPW-1:0] OP_RSA  = 6'b011011;
  localparam logic [OPW-1:0] OP_JC   = 6'b011100;
  localparam logic [OPW-1:0] OP_JNC  = 6'b011101;
  localparam logic [OPW-1:0] OP_JZ   = 6'b011110;
  localparam logic [OPW-1:0] OP_JNZ  = 6'b011111;

  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_ALU,
    CLS_SHIFT,
    CLS_PASS_B,
    CLS_PASS_A,
    CLS_ST,
    CLS_IN,
    CLS_OUT
  } op_cls_t;

  // MOV/MVI go to PASS_B, not ALU, because they must leave the flags alone.
  function automatic op_cls_t op_class(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XORI, OP_NTI:   return CLS_ALU;
      OP_LS, OP_RS, OP_RSA:                               return CLS_SHIFT;
      OP_MOV, OP_MVI, OP_LD, OP_JMP,
      OP_JC, OP_JNC, OP_JZ, OP_JNZ:                       return CLS_PASS_B;
      OP_RET, OP_HLT:                                     return CLS_PASS_A;
      OP_ST:                                              return CLS_ST;
      OP_IN:                                              return CLS_IN;
      OP_OUT:                                             return CLS_OUT;
      default:                                            return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU and barrel shifter of the execute stage: 16-bit result plus carry and zero.
module ex_alu
  import ex_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  input  logic          shift,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [3:0]           amt;
  logic [DW:0]          sum;
  logic [DW:0]          diff;
  logic [DW:0]          lsh;
  logic [DW:0]          rsh;
  logic signed [DW:0]   rsa;

  assign amt  = b[3:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // One guard bit catches the last bit shifted out; an amount of 0 leaves it clear.
  assign lsh = {1'b0, a} << amt;
  assign rsh = {a, 1'b0} >> amt;
  assign rsa = $signed({a, 1'b0}) >>> amt;

  always_comb begin
    result = b;
    carry  = 1'b0;
    if (shift) begin
      case (op[1:0])
        2'b01: begin result = lsh[DW-1:0]; carry = lsh[DW]; end
        2'b10: begin result = rsh[DW:1];   carry = rsh[0];  end
        2'b11: begin result = rsa[DW:1];   carry = rsa[0];  end
        default: result = a;
      endcase
    end else begin
      case (op)
        3'b000: begin result = sum[DW-1:0];  carry = sum[DW];  end
        3'b001: begin result = diff[DW-1:0]; carry = diff[DW]; end
        3'b100: result = a & b;
        3'b101: result = a | b;
        3'b110: result = a ^ b;
        3'b111: result = ~a;
        default: result = b;
      endcase
    end
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_block.sv
// Execute stage: decodes op_dec, runs ex_alu and registers result, store data, port data and flags.
module ex_block
  import ex_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [DW-1:0]  A,
  input  logic [DW-1:0]  B,
  input  logic [DW-1:0]  data_in,
  input  logic [OPW-1:0] op_dec,
  output logic [DW-1:0]  ans_ex,
  output logic [DW-1:0]  DM_data,
  output logic [DW-1:0]  data_out,
  output logic [1:0]     flag_ex
);

  op_cls_t       cls;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          alu_zero;

  logic [DW-1:0] ans_nxt;
  logic [DW-1:0] dm_nxt;
  logic [DW-1:0] out_nxt;
  logic [1:0]    flag_nxt;

  assign cls = op_class(op_dec);

  ex_alu u_alu (
    .a      (A),
    .b      (B),
    .op     (op_dec[2:0]),
    .shift  (cls == CLS_SHIFT),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    ans_nxt  = ans_ex;
    dm_nxt   = DM_data;
    out_nxt  = data_out;
    flag_nxt = flag_ex;
    case (cls)
      CLS_ALU, CLS_SHIFT: begin
        ans_nxt          = alu_result;
        flag_nxt[FLAG_C] = alu_carry;
        flag_nxt[FLAG_Z] = alu_zero;
      end
      CLS_PASS_B: ans_nxt = B;
      CLS_PASS_A: ans_nxt = A;
      CLS_ST: begin
        ans_nxt = B;
        dm_nxt  = A;
      end
      CLS_IN: ans_nxt = data_in;
      CLS_OUT: begin
        ans_nxt = A;
        out_nxt = A;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans_ex   <= '0;
      DM_data  <= '0;
      data_out <= '0;
      flag_ex  <= 2'b00;
    end else begin
      ans_ex   <= ans_nxt;
      DM_data  <= dm_nxt;
      data_out <= out_nxt;
      flag_ex  <= flag_nxt;
    end
  end

endmodule

// File: tb/tb_ex_block.sv
// Directed and randomized checks of ex_block against an arithmetic reference model.
module tb_ex_block;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A, B, data_in;
  logic [5:0]  op_dec;
  logic [15:0] ans_ex, DM_data, data_out;
  logic [1:0]  flag_ex;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_ans, m_dm, m_out;
  logic        m_c, m_z;

  always #5 clk = ~clk;

  ex_block dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .data_in  (data_in),
    .op_dec   (op_dec),
    .ans_ex   (ans_ex),
    .DM_data  (DM_data),
    .data_out (data_out),
    .flag_ex  (flag_ex)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: applies the instruction-set rules directly with integer arithmetic.
  task automatic model(input int op, input int a, input int b, input int din, input bit rst);
    int r;
    int n;
    int sa;
    if (rst) begin
      m_ans = 16'h0; m_dm = 16'h0; m_out = 16'h0; m_c = 1'b0; m_z = 1'b0;
      return;
    end
    n = b % 16;
    case (op)
      0, 8:   begin r = a + b; m_c = (r > 65535); r = r % 65536; m_ans = 16'(r); m_z = (r == 0); end
      1, 9:   begin r = (a - b + 65536) % 65536; m_c = (a < b); m_ans = 16'(r); m_z = (r == 0); end
      4, 12:  begin r = a & b; m_c = 0; m_ans = 16'(r); m_z = (r == 0); end
      5, 13:  begin r = a | b; m_c = 0; m_ans = 16'(r); m_z = (r == 0); end
      6, 14:  begin r = a ^ b; m_c = 0; m_ans = 16'(r); m_z = (r == 0); end
      7, 15:  begin r = 65535 - a; m_c = 0; m_ans = 16'(r); m_z = (r == 0); end
      2, 10, 21, 24, 28, 29, 30, 31: m_ans = 16'(b);
      16, 17: m_ans = 16'(a);
      20:     begin m_ans = 16'(b); m_dm = 16'(a); end
      22:     m_ans = 16'(din);
      23:     begin m_ans = 16'(a); m_out = 16'(a); end
      25: begin
        r   = (a * (1 << n)) % 65536;
        m_c = (n == 0) ? 1'b0 : 1'(((a * (1 << n)) / 65536) % 2);
        m_ans = 16'(r); m_z = (r == 0);
      end
      26, 27: begin
        sa = (op == 27 && a >= 32768) ? a - 65536 : a;
        r  = (sa >>> n) & 32'hFFFF;
        m_c = (n == 0) ? 1'b0 : 1'((a / (1 << (n - 1))) % 2);
        m_ans = 16'(r); m_z = (r == 0);
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] din, input bit rst);
    op_dec = op; A = a; B = b; data_in = din; reset = rst;
    @(posedge clk);
    #1;
    model(int'(op), int'(a), int'(b), int'(din), rst);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ans"},  ans_ex,   m_ans);
    chk({tag, ".dm"},   DM_data,  m_dm);
    chk({tag, ".out"},  data_out, m_out);
    chk({tag, ".flag"}, {14'd0, flag_ex}, {14'd0, m_c, m_z});
  endtask

  initial begin
    logic [5:0]  op;
    logic [15:0] a, b;
    bit          rst;

    // Preload nonzero state so reset visibly clears it.
    step(6'b010100, 16'h1234, 16'h5678, 16'h0, 1'b1);
    step(6'b010100, 16'h1234, 16'h5678, 16'h0, 1'b0);
    step(6'b010111, 16'h1111, 16'h0, 16'h0, 1'b0);
    step(6'b000001, 16'h0001, 16'h0002, 16'h0, 1'b0);
    step(6'b000000, 16'h0040, 16'h00C0, 16'h0, 1'b1);
    chk("rst.ans", ans_ex, 16'h0);
    chk("rst.dm", DM_data, 16'h0);
    chk("rst.out", data_out, 16'h0);
    chk("rst.flag", {14'd0, flag_ex}, 16'h0);

    step(6'b000000, 16'h0040, 16'h00C0, 16'h0, 1'b0);
    chk("add.ans", ans_ex, 16'h0100); chk("add.flag", {14'd0, flag_ex}, 16'h0);
    step(6'b000001, 16'h0040, 16'h00C0, 16'h0, 1'b0);
    chk("sub.ans", ans_ex, 16'hFF80); chk("sub.flag", {14'd0, flag_ex}, 16'h2);
    step(6'b000100, 16'h0040, 16'h00C0, 16'h0, 1'b0);
    chk("and.ans", ans_ex, 16'h0040); chk("and.c", {15'd0, flag_ex[1]}, 16'h0);
    step(6'b000101, 16'h0040, 16'h00C0, 16'h0, 1'b0); chk("or.ans", ans_ex, 16'h00C0);
    step(6'b000110, 16'h0040, 16'h00C0, 16'h0, 1'b0); chk("xor.ans", ans_ex, 16'h0080);
    step(6'b000111, 16'h0040, 16'h00C0, 16'h0, 1'b0); chk("not.ans", ans_ex, 16'hFFBF);
    step(6'b001100, 16'h0040, 16'h0000, 16'h0, 1'b0);
    chk("ani.ans", ans_ex, 16'h0); chk("ani.flag", {14'd0, flag_ex}, 16'h1);

    step(6'b011001, 16'h80C0, 16'h0001, 16'h0, 1'b0);
    chk("ls.ans", ans_ex, 16'h0180); chk("ls.c", {15'd0, flag_ex[1]}, 16'h1);
    step(6'b011010, 16'h80C0, 16'h0001, 16'h0, 1'b0);
    chk("rs.ans", ans_ex, 16'h4060); chk("rs.c", {15'd0, flag_ex[1]}, 16'h0);
    step(6'b011011, 16'h80C0, 16'h0001, 16'h0, 1'b0);
    chk("rsa.ans", ans_ex, 16'hC060); chk("rsa.c", {15'd0, flag_ex[1]}, 16'h0);
    step(6'b011011, 16'h80C1, 16'h0010, 16'h0, 1'b0);
    chk("sh0.ans", ans_ex, 16'h80C1); chk("sh0.c", {15'd0, flag_ex[1]}, 16'h0);

    step(6'b010100, 16'h0040, 16'h00C0, 16'h0008, 1'b0);
    chk("st.ans", ans_ex, 16'h00C0); chk("st.dm", DM_data, 16'h0040);
    step(6'b010101, 16'h0041, 16'h00C0, 16'h0008, 1'b0);
    chk("ld.ans", ans_ex, 16'h00C0); chk("ld.dm", DM_data, 16'h0040);
    step(6'b010110, 16'h0040, 16'h00C0, 16'h0008, 1'b0); chk("in.ans", ans_ex, 16'h0008);
    step(6'b010111, 16'h0040, 16'h00C0, 16'h0008, 1'b0);
    chk("out.dat", data_out, 16'h0040); chk("out.ans", ans_ex, 16'h0040);

    step(6'b000001, 16'h0040, 16'h00C0, 16'h0, 1'b0);
    step(6'b000010, 16'h0040, 16'h0011, 16'h0, 1'b0);
    chk("mov.ans", ans_ex, 16'h0011); chk("mov.flag", {14'd0, flag_ex}, 16'h2);
    step(6'b011000, 16'h0040, 16'h0022, 16'h0, 1'b0);
    chk("jmp.ans", ans_ex, 16'h0022); chk("jmp.flag", {14'd0, flag_ex}, 16'h2);
    step(6'b011100, 16'h0040, 16'h0033, 16'h0, 1'b0);
    chk("jc.ans", ans_ex, 16'h0033); chk("jc.flag", {14'd0, flag_ex}, 16'h2);
    step(6'b011111, 16'h0040, 16'h0044, 16'h0, 1'b0);
    chk("jnz.ans", ans_ex, 16'h0044); chk("jnz.flag", {14'd0, flag_ex}, 16'h2);
    step(6'b000011, 16'h9999, 16'h7777, 16'h5555, 1'b0);
    chk("unl.ans", ans_ex, 16'h0044); chk("unl.dm", DM_data, 16'h0040);
    chk("unl.out", data_out, 16'h0040); chk("unl.flag", {14'd0, flag_ex}, 16'h2);

    step(6'b000000, 16'h0040, 16'h00C0, 16'h0, 1'b1);
    chk("rstop.ans", ans_ex, 16'h0); chk("rstop.dm", DM_data, 16'h0);
    step(6'b000000, 16'h0040, 16'h00C0, 16'h0, 1'b0);
    chk("rstop.next", ans_ex, 16'h0100);
    chk_all("dir");

    for (int i = 0; i < 400; i++) begin
      op  = 6'($urandom_range(0, 31));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = b;
      rst = ($urandom_range(0, 39) == 0);
      step(op, a, b, 16'($urandom), rst);
      chk_all($sformatf("rnd%0d.op%0d", i, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
